// File: rtl/load_queue.sv
// load_queue: in-order circular load queue issuing one load per cycle to MEM.
// Optional same-edge issue of an incoming load into an empty queue under LQ_BYPASS_EN.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

module load_queue #(
    parameter int LQ_DEPTH = 4,
    parameter int CNT_W    = $clog2(LQ_DEPTH) + 1
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [`XLEN+`ROB_TAG_LEN+2:0]         lb_packet_in,
    input  logic                                  alloc_enable,
    input  logic                                  pending_stores,
    input  logic                                  mem_busy,
    input  logic                                  flush,
    output logic [`XLEN+`ROB_TAG_LEN+2:0]         lb_packet_out,
    output logic                                  full,
    output logic                                  empty,
    output logic [CNT_W-1:0]                      count,
    output logic [`XLEN-1:0]                      load_address,
    output logic [`ROB_TAG_LEN-1:0]               load_rob_tag,
    output logic                                  read_mem
);
    localparam int PW    = `XLEN + `ROB_TAG_LEN + 3;
    localparam int IDX_W = $clog2(LQ_DEPTH);

    logic [PW-1:0]    entries [LQ_DEPTH];
    logic [IDX_W-1:0] head, tail;
    logic             alloc, issue, bypass, enq;

    assign full          = count == CNT_W'(LQ_DEPTH);
    assign empty         = count == '0;
    assign lb_packet_out = empty ? '0 : entries[head];
    assign alloc         = alloc_enable && lb_packet_in[PW-1] && !full;
    assign issue         = !empty && !pending_stores && !mem_busy;
`ifdef LQ_BYPASS_EN
    assign bypass        = empty && alloc && !pending_stores && !mem_busy;
`else
    assign bypass        = 1'b0;
`endif
    assign enq           = alloc && !bypass;

    // Full/empty come from count, so head==tail is unambiguous for the pointers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            read_mem     <= 1'b0;
            load_address <= '0;
            load_rob_tag <= '0;
            for (int i = 0; i < LQ_DEPTH; i++) entries[i] <= '0;
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            read_mem <= 1'b0;
            for (int i = 0; i < LQ_DEPTH; i++) entries[i] <= '0;
        end else begin
            read_mem <= issue || bypass;
            if (issue) begin
                load_address  <= entries[head][PW-2 -: `XLEN];
                load_rob_tag  <= entries[head][`ROB_TAG_LEN+1:2];
                entries[head] <= '0;
                head          <= head + 1'b1;
            end
            if (bypass) begin
                load_address <= lb_packet_in[PW-2 -: `XLEN];
                load_rob_tag <= lb_packet_in[`ROB_TAG_LEN+1:2];
            end
            if (enq) begin
                entries[tail] <= lb_packet_in;
                tail          <= tail + 1'b1;
            end
            count <= count + CNT_W'(enq) - CNT_W'(issue);
        end
    end
endmodule

// File: tb/tb_load_queue.sv
// tb_load_queue: directed and random stimulus against a queue-based reference model.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

module tb_load_queue;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;
    localparam int PW = `XLEN + `ROB_TAG_LEN + 3;

    logic                    clock = 0, reset = 0;
    logic [PW-1:0]           lb_packet_in = '0, lb_packet_out;
    logic                    alloc_enable = 0, pending_stores = 0, mem_busy = 0, flush = 0;
    logic                    full, empty, read_mem;
    logic [CW-1:0]           count;
    logic [`XLEN-1:0]        load_address;
    logic [`ROB_TAG_LEN-1:0] load_rob_tag;

    load_queue #(.LQ_DEPTH(D)) dut (
        .clock(clock), .reset(reset), .lb_packet_in(lb_packet_in),
        .alloc_enable(alloc_enable), .pending_stores(pending_stores),
        .mem_busy(mem_busy), .flush(flush), .lb_packet_out(lb_packet_out),
        .full(full), .empty(empty), .count(count), .load_address(load_address),
        .load_rob_tag(load_rob_tag), .read_mem(read_mem)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    logic [PW-1:0]           q [$];
    logic                    m_rm = 0;
    logic [`XLEN-1:0]        m_la = '0;
    logic [`ROB_TAG_LEN-1:0] m_lt = '0;

    function automatic logic [PW-1:0] pk(input logic v, input int a, input int t, input int s);
        return {v, `XLEN'(a), `ROB_TAG_LEN'(t), 2'(s)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rm = 0;
        m_la = '0;
        m_lt = '0;
    endtask

    task automatic compare_all();
        chk("count", 64'(count), 64'(q.size()));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("full", 64'(full), 64'(q.size() == D));
        chk("read_mem", 64'(read_mem), 64'(m_rm));
        chk("load_address", 64'(load_address), 64'(m_la));
        chk("load_rob_tag", 64'(load_rob_tag), 64'(m_lt));
        chk("lb_packet_out", 64'(lb_packet_out), q.size() ? 64'(q[0]) : 64'd0);
    endtask

    // One clock: model the edge from the inputs held since the last negedge, then compare.
    task automatic step();
        bit was_empty, was_full, iss, acc;
        @(posedge clock);
        was_empty = q.size() == 0;
        was_full  = q.size() == D;
        if (flush) begin
            q.delete();
            m_rm = 0;
        end else begin
            iss = !was_empty && !pending_stores && !mem_busy;
            acc = alloc_enable && lb_packet_in[PW-1] && !was_full;
            m_rm = iss;
            if (iss) begin
                m_la = q[0][PW-2 -: `XLEN];
                m_lt = q[0][`ROB_TAG_LEN+1:2];
                void'(q.pop_front());
            end
`ifdef LQ_BYPASS_EN
            if (acc && was_empty && !pending_stores && !mem_busy) begin
                m_rm = 1;
                m_la = lb_packet_in[PW-2 -: `XLEN];
                m_lt = lb_packet_in[`ROB_TAG_LEN+1:2];
                acc  = 0;
            end
`endif
            if (acc) q.push_back(lb_packet_in);
        end
        @(negedge clock);
        compare_all();
    endtask

    initial begin
        @(negedge clock);
        @(negedge clock);
        model_reset();
        compare_all();
        reset = 1;
        step();
        step();
        // single load
        alloc_enable = 1; lb_packet_in = pk(1, 5, 1, 1);
        step();
        alloc_enable = 0;
        step();
        step();
        // fill under pending_stores, fifth alloc dropped, then drain in order
        pending_stores = 1;
        for (int i = 0; i < 4; i++) begin
            alloc_enable = 1; lb_packet_in = pk(1, 2 * (i + 1), i + 1, 2);
            step();
        end
        lb_packet_in = pk(1, 10, 7, 2);
        step();
        chk("full_after_fill", 64'(full), 64'd1);
        chk("count_after_fill", 64'(count), 64'd4);
        alloc_enable = 0; pending_stores = 0;
        for (int i = 0; i < 5; i++) step();
        // mem_busy stall with two queued loads
        pending_stores = 1; alloc_enable = 1;
        lb_packet_in = pk(1, 32'h100, 3, 0); step();
        lb_packet_in = pk(1, 32'h104, 4, 0); step();
        alloc_enable = 0; pending_stores = 0; mem_busy = 1;
        for (int i = 0; i < 3; i++) step();
        mem_busy = 0;
        for (int i = 0; i < 3; i++) step();
        // ten alloc/issue pairs wrap the pointers
        for (int i = 0; i < 10; i++) begin
            alloc_enable = 1; lb_packet_in = pk(1, 32'h200 + 4 * i, 10 + i, 3);
            step();
        end
        alloc_enable = 0;
        for (int i = 0; i < 3; i++) step();
        // flush with three queued loads and a concurrent alloc
        pending_stores = 1; alloc_enable = 1;
        for (int i = 0; i < 3; i++) begin
            lb_packet_in = pk(1, 40 + i, 20 + i, 1);
            step();
        end
        flush = 1; lb_packet_in = pk(1, 99, 9, 1);
        step();
        chk("count_after_flush", 64'(count), 64'd0);
        chk("read_mem_after_flush", 64'(read_mem), 64'd0);
        flush = 0; pending_stores = 0;
        lb_packet_in = pk(1, 7, 5, 2);
        step();
        alloc_enable = 0;
        step();
        step();
        // random traffic
        for (int n = 0; n < 400; n++) begin
            alloc_enable   = $urandom_range(0, 3) != 0;
            lb_packet_in   = pk($urandom_range(0, 7) != 0, $urandom, $urandom, $urandom);
            pending_stores = $urandom_range(0, 3) == 0;
            mem_busy       = $urandom_range(0, 3) == 0;
            flush          = $urandom_range(0, 31) == 0;
            step();
        end
        // asynchronous reset mid-operation
        flush = 0; pending_stores = 0; mem_busy = 0;
        alloc_enable = 1; lb_packet_in = pk(1, 12, 6, 0);
        step();
        step();
        #2 reset = 0;
        #1;
        model_reset();
        chk("async_read_mem", 64'(read_mem), 64'd0);
        chk("async_count", 64'(count), 64'd0);
        chk("async_empty", 64'(empty), 64'd1);
        chk("async_load_address", 64'(load_address), 64'd0);
        @(negedge clock);
        alloc_enable = 0;
        reset = 1;
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
